// File: rtl/reg_writeback_queue_if.sv
// Producer-side push channel of the register write-back queue.
// The producer (master) offers a destination index and result; the queue (slave) accepts it.
interface reg_writeback_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  // Handshake: a word transfers on a rising edge where wr_valid && wr_ready.
  // The master holds wr_valid, wr_dr and wr_data stable until that edge.
  // wr_ready may depend on same-cycle inputs (flush) but never on wr_valid.
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_dr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_dr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_dr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// FIFO of pending register-file writes with hazard lookup and NZP update on commit.
// Optional macro WB_FORWARD_EN enables youngest-entry data forwarding for sr1/sr2.
module reg_writeback_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_writeback_queue_if.slave     wr,
  input  logic                     drain_en,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    rf_din,
  output logic [ADDR_WIDTH-1:0]    rf_dr,
  output logic                     rf_ld_reg,
  input  logic [ADDR_WIDTH-1:0]    sr1,
  input  logic [ADDR_WIDTH-1:0]    sr2,
  output logic                     sr1_pending,
  output logic                     sr2_pending,
  output logic [DATA_WIDTH-1:0]    sr1_fwd_data,
  output logic [DATA_WIDTH-1:0]    sr2_fwd_data,
  output logic [2:0]               nzp,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] slot_dr   [DEPTH];
  logic [DATA_WIDTH-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]      slot_valid;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic [2:0]       nzp_q;

  logic       not_empty;
  logic       push;
  logic       pop;
  logic       din_neg;
  logic       din_zero;
  logic [2:0] nzp_next;

  logic [DEPTH-1:0] sr1_hit;
  logic [DEPTH-1:0] sr2_hit;

  // Ready ignores a same-cycle pop so a full queue never accepts.
  assign not_empty   = (count_q != '0);
  assign wr.wr_ready = (count_q != FULL_COUNT) && !flush;
  assign push        = wr.wr_valid && wr.wr_ready;

  assign rf_ld_reg = not_empty && drain_en && !flush;
  assign pop       = rf_ld_reg;
  assign rf_din    = not_empty ? slot_data[head] : '0;
  assign rf_dr     = not_empty ? slot_dr[head]   : '0;

  assign din_neg  = rf_din[DATA_WIDTH-1];
  assign din_zero = (rf_din == '0);
  assign nzp_next = {din_neg, din_zero, !din_neg && !din_zero};

  assign count = count_q;
  assign nzp   = nzp_q;

  // Payload slots are not reset; only the valid bits and pointers matter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      slot_valid <= '0;
      nzp_q      <= 3'b010;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
      slot_valid <= '0;
    end else begin
      if (push) begin
        slot_dr[tail]    <= wr.wr_dr;
        slot_data[tail]  <= wr.wr_data;
        slot_valid[tail] <= 1'b1;
        tail             <= tail + 1'b1;
      end
      if (pop) begin
        slot_valid[head] <= 1'b0;
        head             <= head + 1'b1;
        nzp_q            <= nzp_next;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    sr1_hit = '0;
    sr2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sr1_hit[i] = slot_valid[i] && (slot_dr[i] == sr1);
      sr2_hit[i] = slot_valid[i] && (slot_dr[i] == sr2);
    end
  end

  assign sr1_pending = |sr1_hit;
  assign sr2_pending = |sr2_hit;

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] age_idx;

  // Walk slots oldest-to-youngest from head so the last hit wins, independent of wrap.
  always_comb begin
    sr1_fwd_data = '0;
    sr2_fwd_data = '0;
    age_idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx = head + PTR_W'(i);
      if (sr1_hit[age_idx]) sr1_fwd_data = slot_data[age_idx];
      if (sr2_hit[age_idx]) sr2_fwd_data = slot_data[age_idx];
    end
  end
`else
  assign sr1_fwd_data = '0;
  assign sr2_fwd_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized and directed bench for reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          drain_en;
  logic          flush;
  logic [AW-1:0] sr1;
  logic [AW-1:0] sr2;
  logic [DW-1:0] rf_din;
  logic [AW-1:0] rf_dr;
  logic          rf_ld_reg;
  logic          sr1_pending;
  logic          sr2_pending;
  logic [DW-1:0] sr1_fwd_data;
  logic [DW-1:0] sr2_fwd_data;
  logic [2:0]    nzp;
  logic [CW-1:0] count;

  reg_writeback_queue_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wb ();

  reg_writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wb),
    .drain_en     (drain_en),
    .flush        (flush),
    .rf_din       (rf_din),
    .rf_dr        (rf_dr),
    .rf_ld_reg    (rf_ld_reg),
    .sr1          (sr1),
    .sr2          (sr2),
    .sr1_pending  (sr1_pending),
    .sr2_pending  (sr2_pending),
    .sr1_fwd_data (sr1_fwd_data),
    .sr2_fwd_data (sr2_fwd_data),
    .nzp          (nzp),
    .count        (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: pending writes as {dr, data}, oldest first
  logic [AW+DW-1:0] exp_q[$];
  logic [2:0]       exp_nzp;
  int               n_checks;
  int               n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, compare outputs against the model, then advance the model.
  task automatic step(input logic rst_n, input logic wv, input logic [AW-1:0] d,
                      input logic [DW-1:0] data, input logic drain, input logic fl,
                      input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    int            size;
    logic          e_ready;
    logic          e_ld;
    logic [DW-1:0] e_din;
    logic [AW-1:0] e_dr;
    logic          e_p1;
    logic          e_p2;
    logic [DW-1:0] e_f1;
    logic [DW-1:0] e_f2;
    logic          pushing;
    @(negedge clk);
    reset       = rst_n;
    wb.wr_valid = wv;
    wb.wr_dr    = d;
    wb.wr_data  = data;
    drain_en    = drain;
    flush       = fl;
    sr1         = s1;
    sr2         = s2;
    #1;
    size    = exp_q.size();
    e_ready = (size != DEPTH) && !fl;
    e_ld    = (size != 0) && drain && !fl;
    e_din   = (size != 0) ? exp_q[0][DW-1:0] : '0;
    e_dr    = (size != 0) ? exp_q[0][AW+DW-1:DW] : '0;
    e_p1 = 1'b0; e_p2 = 1'b0; e_f1 = '0; e_f2 = '0;
    for (int i = 0; i < size; i++) begin
      if (exp_q[i][AW+DW-1:DW] == s1) begin e_p1 = 1'b1; e_f1 = exp_q[i][DW-1:0]; end
      if (exp_q[i][AW+DW-1:DW] == s2) begin e_p2 = 1'b1; e_f2 = exp_q[i][DW-1:0]; end
    end
`ifndef WB_FORWARD_EN
    e_f1 = '0;
    e_f2 = '0;
`endif
    check_val("wr_ready",     32'(wb.wr_ready),  32'(e_ready));
    check_val("rf_ld_reg",    32'(rf_ld_reg),    32'(e_ld));
    check_val("rf_din",       32'(rf_din),       32'(e_din));
    check_val("rf_dr",        32'(rf_dr),        32'(e_dr));
    check_val("sr1_pending",  32'(sr1_pending),  32'(e_p1));
    check_val("sr2_pending",  32'(sr2_pending),  32'(e_p2));
    check_val("sr1_fwd_data", 32'(sr1_fwd_data), 32'(e_f1));
    check_val("sr2_fwd_data", 32'(sr2_fwd_data), 32'(e_f2));
    check_val("nzp",          32'(nzp),          32'(exp_nzp));
    check_val("count",        32'(count),        32'(size));
    // model update for the coming edge
    if (!rst_n) begin
      exp_q.delete();
      exp_nzp = 3'b010;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      pushing = wv && e_ready;
      if (e_ld) begin
        if (e_din[DW-1])      exp_nzp = 3'b100;
        else if (e_din == 0)  exp_nzp = 3'b010;
        else                  exp_nzp = 3'b001;
        void'(exp_q.pop_front());
      end
      if (pushing) exp_q.push_back({d, data});
    end
  endtask

  task automatic idle(input logic drain);
    step(1'b1, 1'b0, '0, '0, drain, 1'b0, '0, '0);
  endtask

  task automatic push(input logic [AW-1:0] d, input logic [DW-1:0] data, input logic drain);
    step(1'b1, 1'b1, d, data, drain, 1'b0, '0, '0);
  endtask

  logic [AW-1:0] drain_order[5];
  logic [DW-1:0] rnd_data;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_nzp  = 3'b010;
    reset = 1'b0; flush = 1'b0; drain_en = 1'b0;
    wb.wr_valid = 1'b0; wb.wr_dr = '0; wb.wr_data = '0;
    sr1 = '0; sr2 = '0;
    repeat (2) @(posedge clk);

    // reset with three entries queued
    push(3'd1, 16'h0101, 1'b0);
    push(3'd2, 16'h0202, 1'b0);
    push(3'd3, 16'h0303, 1'b0);
    step(1'b0, 1'b1, 3'd4, 16'h0404, 1'b0, 1'b0, '0, '0);
    idle(1'b0);
    check_val("rst_count", 32'(count),       32'd0);
    check_val("rst_ld",    32'(rf_ld_reg),   32'd0);
    check_val("rst_nzp",   32'(nzp),         32'b010);
    check_val("rst_ready", 32'(wb.wr_ready), 32'd1);

    // single write with one-cycle latency, negative result
    push(3'd3, 16'h8001, 1'b1);
    idle(1'b1);
    check_val("lat_ld",  32'(rf_ld_reg), 32'd1);
    check_val("lat_dr",  32'(rf_dr),     32'd3);
    check_val("lat_din", 32'(rf_din),    32'h8001);
    idle(1'b1);
    check_val("neg_nzp",   32'(nzp),   32'b100);
    check_val("neg_count", 32'(count), 32'd0);

    // fill, hold off a fifth push, then drain in order
    for (int i = 1; i <= 4; i++) push(AW'(i), DW'(16'h0010 + i), 1'b0);
    push(3'd5, 16'h0005, 1'b0);
    check_val("full_count", 32'(count),       32'd4);
    check_val("full_ready", 32'(wb.wr_ready), 32'd0);
    drain_order[0] = 3'd1; drain_order[1] = 3'd2; drain_order[2] = 3'd3;
    drain_order[3] = 3'd4; drain_order[4] = 3'd5;
    for (int k = 0; k < 5; k++) begin
      if (k < 2) push(3'd5, 16'h0005, 1'b1);
      else       idle(1'b1);
      check_val("drain_order", 32'(rf_dr), 32'(drain_order[k]));
    end
    idle(1'b1);
    check_val("drained_count", 32'(count), 32'd0);
    check_val("pos_nzp",       32'(nzp),   32'b001);

    // hazard lookup and zero result
    push(3'd5, 16'h0000, 1'b0);
    push(3'd2, 16'h0007, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 3'd5, 3'd6);
    check_val("haz_sr1", 32'(sr1_pending), 32'd1);
    check_val("haz_sr2", 32'(sr2_pending), 32'd0);
    idle(1'b1);
    idle(1'b0);
    check_val("zero_nzp", 32'(nzp), 32'b010);
    idle(1'b1);
    idle(1'b0);

    // flush while a producer offers a word
    push(3'd1, 16'h1234, 1'b0);
    push(3'd2, 16'h2345, 1'b0);
    push(3'd3, 16'h3456, 1'b0);
    step(1'b1, 1'b1, 3'd6, 16'h6666, 1'b1, 1'b1, '0, '0);
    check_val("flush_ld",    32'(rf_ld_reg),   32'd0);
    check_val("flush_ready", 32'(wb.wr_ready), 32'd0);
    idle(1'b0);
    check_val("flush_count", 32'(count), 32'd0);

    // wrap the pointers, then queue two writes to r7
    push(3'd1, 16'h0001, 1'b0);
    push(3'd2, 16'h0002, 1'b0);
    push(3'd3, 16'h0003, 1'b0);
    repeat (3) idle(1'b1);
    push(3'd7, 16'h1111, 1'b0);
    push(3'd7, 16'h2222, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 3'd7, 3'd1);
    check_val("wrap_pending", 32'(sr1_pending), 32'd1);
`ifdef WB_FORWARD_EN
    check_val("wrap_fwd", 32'(sr1_fwd_data), 32'h2222);
`else
    check_val("wrap_fwd", 32'(sr1_fwd_data), 32'h0000);
`endif
    repeat (3) idle(1'b1);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      case ($urandom_range(0, 7))
        0:       rnd_data = '0;
        1:       rnd_data = 16'h8000 | DW'($urandom_range(0, 16'h7fff));
        default: rnd_data = DW'($urandom_range(0, 16'hffff));
      endcase
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) < 7),
           AW'($urandom_range(0, 7)),
           rnd_data,
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 19) == 0),
           AW'($urandom_range(0, 7)),
           AW'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side companion to the 8x16 register file: buffers destination-register results from the datapath and drives the file's single write port (din, dr, ld_reg), one write per cycle.
- Holds up to DEPTH pending writes in FIFO order.
- Reports per-source-register pending hazards for the two read selects, updates NZP condition codes on each committed write, and optionally forwards queued data.

Parameters:
DATA_WIDTH, 16, width of register data
ADDR_WIDTH, 3, register index width (8 registers)
DEPTH, 4, queue entries; power of 2, at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous reset, active-low
wr_valid  input  1  producer has a result to write
wr_ready  output  1  queue can accept; transfer when wr_valid && wr_ready
wr_dr  input  ADDR_WIDTH  destination register of incoming result
wr_data  input  DATA_WIDTH  incoming result value
drain_en  input  1  permit committing the head entry this cycle
flush  input  1  discard all queued entries
rf_din  output  DATA_WIDTH  register-file write data (head entry)
rf_dr  output  ADDR_WIDTH  register-file write index (head entry)
rf_ld_reg  output  1  register-file write enable
sr1  input  ADDR_WIDTH  read select 1, hazard/forward lookup
sr2  input  ADDR_WIDTH  read select 2, hazard/forward lookup
sr1_pending  output  1  a queued entry targets sr1
sr2_pending  output  1  a queued entry targets sr2
sr1_fwd_data  output  DATA_WIDTH  youngest queued value for sr1
sr2_fwd_data  output  DATA_WIDTH  youngest queued value for sr2
nzp  output  3  condition codes {N,Z,P} of last committed write
count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (reset==0 at a clock edge):
  - head, tail and count clear to 0; all entry valid bits clear; nzp <= 3'b010.
  - This applies mid-operation; queued writes are lost and none commit on that edge.
  - Outputs after the reset edge: wr_ready=1, rf_ld_reg=0, rf_din=0, rf_dr=0, pending=0, fwd_data=0.
- Storage: circular buffer of {dr, data, valid}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately.
- wr_ready = (count != DEPTH) && !flush. It is combinational and does not look ahead at a same-cycle pop, so a full queue never accepts, even while draining.
- Push: on edge with wr_valid && wr_ready, write the entry at tail, set its valid bit, tail+1.
- Commit (combinational):
  - rf_ld_reg = (count != 0) && drain_en && !flush.
  - rf_din / rf_dr = head entry fields when count != 0, else 0.
- Pop: on an edge with rf_ld_reg=1, clear the head valid bit and advance head by 1. The register file captures on the same edge.
- Latency: a result accepted at edge k is written to the file at edge k+1 if the queue was empty and drain_en was high.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Flush: on an edge with flush=1, clear all valid bits, head=tail=0, count=0. No push and no commit occur that cycle; flush has priority over both.
- NZP: on each pop, set from rf_din:
  - N = rf_din[15].
  - Z = (rf_din == 0).
  - P = !N && !Z.
  - Otherwise hold.
- Pending: srX_pending is combinational, true if any valid entry has dr == srX. An entry popping this cycle still counts as pending until the edge.
- Draining stalls indefinitely while drain_en=0; entries and order are preserved.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined: srX_fwd_data = data of the youngest valid entry (closest to tail) with dr == srX. It is 0 when srX_pending=0. Priority is by age, not slot index, and stays correct across pointer wrap.
- Not defined: srX_fwd_data tied to 0. Pending logic is unchanged. The forward comparators are not synthesized.

Test Plan:
1. Reset with queue holding 3 entries -> count=0, rf_ld_reg=0, nzp=3'b010, wr_ready=1 next cycle; no file write.
2. Empty, drain_en=1: push dr=3, data=16'h8001 -> next cycle rf_ld_reg=1, rf_dr=3, rf_din=16'h8001; after that edge nzp=3'b100, count=0.
3. drain_en=0, push 4 entries (dr 1..4) -> count=4, wr_ready=0. A 5th valid is held off. Raise drain_en -> commits appear in order 1,2,3,4 on four consecutive edges. A push offered while full only lands after count<4.
4. drain_en=0, queue {dr=5:16'h0000, dr=2:16'h0007}, sr1=5, sr2=6 -> sr1_pending=1, sr2_pending=0. After commit of 16'h0000, nzp=3'b010.
5. Flush with 3 entries while wr_valid=1 -> next cycle count=0, no write committed, incoming word dropped.
6. WB_FORWARD_EN, pointer-wrapped queue holding dr=7:16'h1111 then dr=7:16'h2222, sr1=7 -> sr1_fwd_data=16'h2222. Without the macro -> 16'h0000.
